// File: rtl/pc_sequencer.sv
// Program-counter sequencer: multi-cycle fetch/decode/execute FSM that steers an
// external PC register and keeps a small circular return-address stack.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_cur,
    input  logic        instr_valid,
    input  logic [2:0]  opclass,
    input  logic        branch_taken,
    input  logic [15:0] target,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [15:0] pc_next,
    output logic        ir_load,
    output logic [2:0]  state,
    output logic        halted,
    output logic        ras_ovf,
    output logic        ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_CALL   = 3'd5;
    localparam logic [2:0] OP_RET    = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [PTR_W-1:0] top_reg;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic [15:0]      ras_mem [RAS_DEPTH];
    logic [15:0]      ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;

    // Depth is a power of two, so pointer arithmetic wraps the ring for free.
    assign top_dec   = top_reg - 1'b1;
    assign ras_top   = ras_mem[top_dec];
    assign ras_full  = (count_reg == CNT_W'(RAS_DEPTH));
    assign ras_empty = (count_reg == '0);

    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b0;
        pc_next    = pc_cur;
        ir_load    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_load    = 1'b1;
                    pc_en      = 1'b1;
                    pc_next    = pc_cur + 16'd1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opclass)
                    OP_JUMP: begin
                        pc_en      = 1'b1;
                        pc_next    = target;
                        state_next = ST_FETCH;
                    end
                    OP_CALL: begin
                        push       = 1'b1;
                        ovf_set    = ras_full;
                        pc_en      = 1'b1;
                        pc_next    = target;
                        state_next = ST_FETCH;
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            unf_set = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            pc_en   = 1'b1;
                            pc_next = ras_top;
                        end
                        state_next = ST_FETCH;
                    end
                    OP_HALT:           state_next = ST_HALT;
                    OP_ALU, OP_BRANCH: state_next = ST_EXEC;
                    default:           state_next = ST_MEM;
                endcase
            end
            ST_EXEC: begin
                if (opclass == OP_BRANCH && branch_taken) begin
                    pc_en   = 1'b1;
                    pc_next = target;
                end
                state_next = (opclass == OP_ALU) ? ST_WB : ST_FETCH;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (opclass == OP_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   state_next = ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase

        // Reset reloads the external PC register, which has no reset of its own.
        if (rst) begin
            state_next = ST_FETCH;
            pc_en      = 1'b1;
            pc_next    = RESET_PC;
            ir_load    = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
            ovf_set    = 1'b0;
            unf_set    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            top_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                top_reg <= top_reg + 1'b1;
                if (!ras_full) begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (pop) begin
                top_reg   <= top_dec;
                count_reg <= count_reg - 1'b1;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
            if (unf_set) begin
                unf_reg <= 1'b1;
            end
        end
    end

    // When full, top_reg already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[top_reg] <= pc_cur;
        end
    end

    assign state   = state_reg;
    assign halted  = (state_reg == ST_HALT) && !rst;
    assign ras_ovf = ovf_reg;
    assign ras_unf = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC register and checks
// outputs against hand-computed values.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_cur;
    logic        instr_valid;
    logic [2:0]  opclass;
    logic        branch_taken;
    logic [15:0] target;
    logic        mem_ready;
    logic        pc_en;
    logic [15:0] pc_next;
    logic        ir_load;
    logic [2:0]  state;
    logic        halted;
    logic        ras_ovf;
    logic        ras_unf;

    logic [15:0] pc_q;
    int          vectors = 0;
    int          errors  = 0;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_CALL   = 3'd5;
    localparam logic [2:0] OP_RET    = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    pc_sequencer #(
        .RESET_PC (16'h0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .instr_valid (instr_valid),
        .opclass     (opclass),
        .branch_taken(branch_taken),
        .target      (target),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .ir_load     (ir_load),
        .state       (state),
        .halted      (halted),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf)
    );

    always #5 clk = ~clk;

    // External PC register driven by the sequencer.
    always @(posedge clk) begin
        if (pc_en) pc_q <= pc_next;
    end
    assign pc_cur = pc_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] exp_next);
        instr_valid = 1'b1;
        #1;
        chk("fetch_ir_load", ir_load, 1);
        chk("fetch_pc_next", pc_next, exp_next);
        cyc();
        instr_valid = 1'b0;
        chk("fetch_to_decode", state, 1);
        chk("fetch_pc", pc_cur, exp_next);
    endtask

    task automatic jump_to(input logic [15:0] tgt, input logic [15:0] fetch_next);
        do_fetch(fetch_next);
        opclass = OP_JUMP;
        target  = tgt;
        #1;
        chk("jump_pc_next", pc_next, tgt);
        cyc();
        chk("jump_pc", pc_cur, tgt);
    endtask

    task automatic do_call(input logic [15:0] fetch_next, input logic [15:0] tgt);
        do_fetch(fetch_next);
        opclass = OP_CALL;
        target  = tgt;
        #1;
        chk("call_pc_next", pc_next, tgt);
        cyc();
        chk("call_pc", pc_cur, tgt);
    endtask

    task automatic do_ret(input logic [15:0] fetch_next, input logic [15:0] ret_addr);
        do_fetch(fetch_next);
        opclass = OP_RET;
        #1;
        chk("ret_pc_en", pc_en, 1);
        chk("ret_pc_next", pc_next, ret_addr);
        cyc();
        chk("ret_pc", pc_cur, ret_addr);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opclass = OP_ALU;
        branch_taken = 1'b0; target = 16'h0000; mem_ready = 1'b0;
        #1;
        chk("rst_pc_en", pc_en, 1);
        chk("rst_pc_next", pc_next, 16'h0000);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_halted", halted, 0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_ovf", ras_ovf, 0);
        chk("rst_unf", ras_unf, 0);
        chk("rst_pc", pc_cur, 16'h0000);

        // ALU: FETCH -> DECODE -> EXEC -> WB -> FETCH
        opclass = OP_ALU;
        do_fetch(16'h0001);
        chk("alu_ir_pulse", ir_load, 0);
        chk("alu_dec_pc_en", pc_en, 0);
        chk("alu_dec_hold", pc_next, 16'h0001);
        cyc(); chk("alu_exec", state, 2);
        cyc(); chk("alu_wb", state, 4);
        cyc(); chk("alu_fetch", state, 0);
        #1;
        chk("wait_ir_load", ir_load, 0);
        chk("wait_pc_en", pc_en, 0);
        cyc(); chk("wait_state", state, 0);

        // Branch taken
        jump_to(16'h0010, 16'h0002);
        do_fetch(16'h0011);
        opclass = OP_BRANCH;
        #1;
        cyc(); chk("br_exec", state, 2);
        branch_taken = 1'b1; target = 16'h0040;
        #1;
        chk("br_t_pc_en", pc_en, 1);
        chk("br_t_pc_next", pc_next, 16'h0040);
        cyc();
        branch_taken = 1'b0;
        chk("br_t_state", state, 0);
        chk("br_t_pc", pc_cur, 16'h0040);

        // Branch not taken
        jump_to(16'h0010, 16'h0041);
        do_fetch(16'h0011);
        opclass = OP_BRANCH;
        #1;
        cyc();
        branch_taken = 1'b0; target = 16'h0040;
        #1;
        chk("br_nt_pc_en", pc_en, 0);
        chk("br_nt_pc_next", pc_next, 16'h0011);
        cyc();
        chk("br_nt_state", state, 0);
        chk("br_nt_pc", pc_cur, 16'h0011);

        // Simple CALL / RET
        jump_to(16'h0020, 16'h0012);
        do_call(16'h0021, 16'h0100);
        do_ret(16'h0101, 16'h0021);
        chk("callret_ovf", ras_ovf, 0);
        chk("callret_unf", ras_unf, 0);

        // Five nested calls into a 4-deep stack, then five returns
        do_call(16'h0022, 16'h1000);
        chk("nest1_ovf", ras_ovf, 0);
        do_call(16'h1001, 16'h2000);
        do_call(16'h2001, 16'h3000);
        do_call(16'h3001, 16'h4000);
        chk("nest4_ovf", ras_ovf, 0);
        do_call(16'h4001, 16'h5000);
        chk("nest5_ovf", ras_ovf, 1);
        do_ret(16'h5001, 16'h4001);
        do_ret(16'h4002, 16'h3001);
        do_ret(16'h3002, 16'h2001);
        do_ret(16'h2002, 16'h1001);
        chk("ret4_unf", ras_unf, 0);
        do_fetch(16'h1002);
        opclass = OP_RET;
        #1;
        chk("unf_pc_en", pc_en, 0);
        chk("unf_pc_next", pc_next, 16'h1002);
        cyc();
        chk("unf_flag", ras_unf, 1);
        chk("unf_state", state, 0);
        chk("unf_pc", pc_cur, 16'h1002);
        chk("unf_ovf_sticky", ras_ovf, 1);

        // LOAD with three wait cycles
        do_fetch(16'h1003);
        opclass = OP_LOAD; mem_ready = 1'b0;
        #1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("load_wait_state", state, 3);
            chk("load_wait_pc_en", pc_en, 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("load_rdy_state", state, 3);
        chk("load_rdy_pc_en", pc_en, 0);
        cyc();
        mem_ready = 1'b0;
        chk("load_wb", state, 4);
        cyc();
        chk("load_fetch", state, 0);
        chk("load_pc", pc_cur, 16'h1003);

        // STORE completes straight back to FETCH
        do_fetch(16'h1004);
        opclass = OP_STORE;
        #1;
        cyc();
        chk("store_mem", state, 3);
        mem_ready = 1'b1;
        #1;
        cyc();
        mem_ready = 1'b0;
        chk("store_fetch", state, 0);

        // PC wrap, then HALT
        jump_to(16'hFFFF, 16'h1005);
        do_fetch(16'h0000);
        opclass = OP_HALT;
        #1;
        cyc();
        chk("halt_state", state, 5);
        chk("halt_flag", halted, 1);
        instr_valid = 1'b1;
        cyc();
        chk("halt_stay", state, 5);
        chk("halt_pc_en", pc_en, 0);
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_pc_en", pc_en, 1);
        chk("halt_rst_pc_next", pc_next, 16'h0000);
        cyc();
        rst = 1'b0;
        #1;
        chk("halt_rst_state", state, 0);
        chk("halt_rst_pc", pc_cur, 16'h0000);
        chk("halt_rst_ovf", ras_ovf, 0);
        chk("halt_rst_unf", ras_unf, 0);

        // Reset emptied the stack: RET underflows
        do_fetch(16'h0001);
        opclass = OP_RET;
        #1;
        chk("post_rst_ret_pc_en", pc_en, 0);
        cyc();
        chk("post_rst_unf", ras_unf, 1);

        // Reset during a MEM wait
        do_fetch(16'h0002);
        opclass = OP_LOAD; mem_ready = 1'b0;
        #1;
        cyc();
        chk("memrst_mem", state, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("memrst_state", state, 0);
        chk("memrst_unf", ras_unf, 0);
        chk("memrst_pc", pc_cur, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
